// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e    : FSM state encoding (3 bits)
//   cnt_width  : width of the iteration counter for a given operand width
package seq_div_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StSub   = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Counter must hold the value WIDTH itself, hence w+1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_control.sv
// Sequencing FSM for the restoring divider.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : division request, honoured only in IDLE
//   divisor_is_zero  : divisor input is zero (looked at in LOAD)
//   count_zero       : all quotient bits have been shifted in
//   trial_neg        : trial subtraction result is negative
//   load, shift      : datapath strobes for LOAD / SHIFT steps
//   sub_en           : commit the trial subtraction this cycle
//   finish           : DONE state, publish results
//   busy             : state is not IDLE
//   done             : one-cycle completion pulse (registered)
module seq_divider_control
  import seq_div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divisor_is_zero,
  input  logic count_zero,
  input  logic trial_neg,
  output logic load,
  output logic shift,
  output logic sub_en,
  output logic finish,
  output logic busy,
  output logic done
);

  state_e state_q, state_d;
  logic   done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Pulse aligns with the results being published on the DONE exit edge.
      done_q  <= (state_q == StDone);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    sub_en  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        state_d = divisor_is_zero ? StDone : StShift;
      end
      StShift: begin
        shift   = 1'b1;
        state_d = StSub;
      end
      StSub: begin
        sub_en  = ~trial_neg;
        state_d = count_zero ? StDone : StShift;
      end
      StDone: begin
        finish  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per SHIFT/SUB pair.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request a division (ignored while busy)
//   dividend     : unsigned numerator, captured in LOAD
//   divisor      : unsigned denominator, captured in LOAD
//   quotient     : registered quotient, held until the next completion
//   remainder    : registered remainder, held until the next completion
//   busy         : division in progress
//   done         : one-cycle completion pulse
//   div_by_zero  : divisor was zero for the last completed division
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             dz_q;

  logic             load, shift, sub_en, finish;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic             count_zero;
  logic             divisor_is_zero;

  // Partial remainder never exceeds 2*divisor-1, so bit WIDTH of the
  // difference is a reliable sign bit.
  assign trial           = rem_q - {1'b0, dvs_q};
  assign trial_neg       = trial[WIDTH];
  // Counter steps in SHIFT, so SUB already sees the decremented value.
  assign count_zero      = (cnt_q == '0);
  assign divisor_is_zero = (divisor == '0);

  seq_divider_control u_control (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .divisor_is_zero (divisor_is_zero),
    .count_zero      (count_zero),
    .trial_neg       (trial_neg),
    .load            (load),
    .shift           (shift),
    .sub_en          (sub_en),
    .finish          (finish),
    .busy            (busy),
    .done            (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else if (load) begin
      dvs_q <= divisor;
      cnt_q <= CntW'(WIDTH);
      if (divisor_is_zero) begin
        quo_q <= '1;
        rem_q <= {1'b0, dividend};
        dz_q  <= 1'b1;
      end else begin
        quo_q <= dividend;
        rem_q <= '0;
        dz_q  <= 1'b0;
      end
    end else if (shift) begin
      {rem_q, quo_q} <= {rem_q[WIDTH-1:0], quo_q, 1'b0};
      cnt_q          <= cnt_q - CntW'(1);
    end else if (sub_en) begin
      rem_q    <= trial;
      quo_q[0] <= 1'b1;
    end
  end

  // Published results only change on the DONE exit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (finish) begin
      quotient    <= quo_q;
      remainder   <= rem_q[WIDTH-1:0];
      div_by_zero <= dz_q;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: directed 4-bit cases plus an 8-bit random sweep,
// both checked against plain integer division.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] dividend4 = '0, divisor4 = '0;
  logic [3:0] quotient4, remainder4;
  logic       busy4, done4, dz4;

  logic       start8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0;
  logic [7:0] quotient8, remainder8;
  logic       busy8, done8, dz8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .dividend    (dividend4),
    .divisor     (divisor4),
    .quotient    (quotient4),
    .remainder   (remainder4),
    .busy        (busy4),
    .done        (done4),
    .div_by_zero (dz4)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .quotient    (quotient8),
    .remainder   (remainder8),
    .busy        (busy8),
    .done        (done8),
    .div_by_zero (dz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 4-bit division; inputs are scrambled once the operands are latched.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input string tag);
    logic [3:0] eq, er;
    logic       edz;
    int         elat, lat;
    if (b == 0) begin
      eq = 4'hf; er = a; edz = 1'b1; elat = 2;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = 2 * 4 + 2;
    end
    dividend4 = a; divisor4 = b; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        dividend4 = ~a; divisor4 = ~b;
      end
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " quotient"}, quotient4, eq);
    check({tag, " remainder"}, remainder4, er);
    check({tag, " div_by_zero"}, dz4, edz);
    @(posedge clk); #1;
    check({tag, " done width"}, done4, 0);
    check({tag, " quotient hold"}, quotient4, eq);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    logic       edz;
    int         elat, lat;
    if (b == 0) begin
      eq = 8'hff; er = a; edz = 1'b1; elat = 2;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = 2 * 8 + 2;
    end
    dividend8 = a; divisor8 = b; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        dividend8 = 8'($urandom); divisor8 = 8'($urandom);
      end
    end
    check($sformatf("%0d/%0d latency", a, b), lat, elat);
    check($sformatf("%0d/%0d quotient", a, b), quotient8, eq);
    check($sformatf("%0d/%0d remainder", a, b), remainder8, er);
    check($sformatf("%0d/%0d div_by_zero", a, b), dz8, edz);
    if (b != 0) begin
      check($sformatf("%0d/%0d identity", a, b), 32'(quotient8) * 32'(b) + 32'(remainder8),
            32'(a));
      check($sformatf("%0d/%0d rem<div", a, b), 32'(remainder8 < b), 1);
    end
  endtask

  initial begin
    int         ndone;
    logic [3:0] cq, cr;

    repeat (2) @(posedge clk);
    #1;
    check("reset quotient4", quotient4, 0);
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset quotient8", quotient8, 0);
    rst = 1'b0;

    run4(4'd13, 4'd4, "13/4");
    run4(4'd7, 4'd0, "7/0");
    run4(4'd15, 4'd15, "15/15");
    run4(4'd0, 4'd5, "0/5");
    run4(4'd3, 4'd9, "3/9");

    // Second start while busy must be ignored.
    dividend4 = 4'd11; divisor4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("busy mid-division", busy4, 1);
    dividend4 = 4'd2; divisor4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    ndone = 0; cq = '0; cr = '0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done4) begin
        ndone++; cq = quotient4; cr = remainder4;
      end
    end
    check("busy-start done count", ndone, 1);
    check("busy-start quotient", cq, 3);
    check("busy-start remainder", cr, 2);

    // Reset in the middle of a division.
    dividend4 = 4'd14; divisor4 = 4'd3; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midreset quotient", quotient4, 0);
    check("midreset remainder", remainder4, 0);
    check("midreset div_by_zero", dz4, 0);
    check("midreset busy", busy4, 0);
    check("midreset done", done4, 0);
    @(posedge clk); #1 rst = 1'b0;
    run4(4'd9, 4'd2, "9/2 after reset");

    run8(8'd255, 8'd1);
    run8(8'd255, 8'd255);
    run8(8'd0, 8'd7);
    run8(8'd200, 8'd0);
    run8(8'd5, 8'd250);
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i % 16 == 0) ? 8'd0 : 8'($urandom);
      run8(a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured in LOAD.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured in LOAD.
REQ-007 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-008 The block SHALL have port remainder, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag, valid while done is high and held afterwards.

Function
REQ-012 The FSM SHALL use states IDLE, LOAD, SHIFT, SUB, and DONE.
REQ-013 IDLE SHALL go to LOAD when start=1 and SHALL stay in IDLE otherwise.
REQ-014 LOAD SHALL capture the operands, clear the partial remainder (WIDTH+1 bits), clear div_by_zero, and load the bit counter with WIDTH.
REQ-015 LOAD SHALL go to DONE with quotient = all ones, remainder = dividend and div_by_zero = 1 when divisor = 0; otherwise LOAD SHALL go to SHIFT.
REQ-016 SHIFT SHALL shift {partial remainder, quotient register} left by one, shifting 0 into the quotient LSB, and SHALL then go to SUB.
REQ-017 SUB SHALL trial-subtract the divisor (zero-extended to WIDTH+1) from the partial remainder.
REQ-018 In SUB, a non-negative trial result SHALL replace the partial remainder and set quotient bit 0 to 1; a negative result SHALL leave both unchanged (restoring).
REQ-019 SUB SHALL decrement the counter, go to SHIFT while the counter is still nonzero after the decrement, and go to DONE when it reaches 0.
REQ-020 DONE SHALL drive done=1 for exactly one cycle, SHALL publish quotient and remainder (the low WIDTH bits of the partial remainder), and SHALL return to IDLE.
REQ-021 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+2*WIDTH+2 for a nonzero divisor, and after edge k+2 for a zero divisor.
REQ-022 The block SHALL ignore start while busy; a start held high continuously SHALL begin a new division on the edge after DONE returns to IDLE.
REQ-023 quotient, remainder, and div_by_zero SHALL hold their values from DONE until the next DONE.
REQ-024 Operands SHALL be sampled only in LOAD; input changes during SHIFT/SUB SHALL not affect the result.
REQ-025 The results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor, including dividend < divisor and dividend = 0.

Reset
REQ-026 Asserting rst SHALL immediately force the state to IDLE, regardless of state and even mid-division.
REQ-027 Asserting rst SHALL immediately clear quotient, remainder, div_by_zero, done, busy, the counter, and the partial remainder to 0.
REQ-028 After rst deasserts, the first start SHALL be sampled on the first rising edge.

Structure
REQ-029 Package seq_div_pkg SHALL hold the state encoding (IDLE=0, LOAD=1, SHIFT=2, SUB=3, DONE=4, 3 bits) and the counter-width constant expression.
REQ-030 The FSM SHALL be the sub-module seq_divider_control, with inputs start, divisor_is_zero, count_zero, and trial_neg.
REQ-031 seq_divider_control SHALL output load, shift, sub_en, finish, busy, and done.
REQ-032 The datapath registers and subtractor SHALL reside in seq_divider.

Verification (WIDTH=4 unless stated)
REQ-033 Test 13/4: pulse start with dividend=13, divisor=4 -> done high 10 cycles after the start edge, quotient=3, remainder=1, div_by_zero=0.
REQ-034 Test 7/0 and 15/15: 7/0 -> done 2 cycles after start, quotient=15, remainder=7, div_by_zero=1; then 15/15 -> quotient=1, remainder=0, div_by_zero=0.
REQ-035 Test 0/5 and 3/9: 0/5 -> quotient=0, remainder=0; 3/9 -> quotient=0, remainder=3.
REQ-036 Test start during busy: pulse start again mid-division with new operands -> the first result is unchanged, exactly one done pulse occurs, and the second start is ignored.
REQ-037 Test reset mid-operation: assert rst at cycle 5 of a division -> all outputs read 0 before the next clock edge; a subsequent 9/2 -> quotient=4, remainder=1.
REQ-038 Test sweep: with WIDTH=8, sweep random operands against a reference model, including 255/1 -> 255/0 and 255/255 -> 1/0, and check REQ-025 on every result.
